// File: rtl/cic_dec_ctrl.sv
// rtl/cic_dec_ctrl.sv - CIC decimator control: output strobe, reconfiguration flush and overflow statistics
module cic_dec_ctrl #(
  parameter int FLUSH_CYC = 4,
  parameter int CW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          in_vld,
  input  logic          cfg_load,
  input  logic [2:0]    cfg_os,
  input  logic [1:0]    flag_t,
  input  logic          ovf_clr,
  output logic [2:0]    os_sel,
  output logic          dec_stb,
  output logic          integ_clr,
  output logic          busy,
  output logic          cfg_err,
  output logic [CW-1:0] ovf_cnt,
  output logic          ovf_pos,
  output logic          ovf_neg
);

  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, CLEAR} state_t;

  state_t        state, state_nxt;
  logic [2:0]    pending, pending_nxt, os_sel_nxt;
  logic [5:0]    cnt, cnt_nxt, lim;
  logic [FW-1:0] flush_cnt, flush_cnt_nxt;
  logic          dec_stb_nxt, integ_clr_nxt, busy_nxt, cfg_err_nxt;
  logic [CW-1:0] ovf_cnt_nxt;
  logic          ovf_pos_nxt, ovf_neg_nxt;
  logic          flag_q, trunc_evt, cfg_ok, wrap;

  // R-1 as a low-bit mask: os_sel=0 -> 0, os_sel=6 -> 63
  assign lim       = ~(6'h3F << os_sel);
  assign wrap      = in_vld && (cnt == lim);
  assign cfg_ok    = cfg_load && (cfg_os != 3'b111);
  assign trunc_evt = flag_t[0] ^ flag_q;

  always_comb begin
    state_nxt     = state;
    pending_nxt   = pending;
    os_sel_nxt    = os_sel;
    cnt_nxt       = cnt;
    flush_cnt_nxt = flush_cnt;
    dec_stb_nxt   = 1'b0;
    integ_clr_nxt = integ_clr;
    busy_nxt      = busy;
    cfg_err_nxt   = cfg_load && (cfg_os == 3'b111);

    if (!en) begin
      state_nxt     = IDLE;
      cnt_nxt       = 6'd0;
      integ_clr_nxt = 1'b0;
      busy_nxt      = 1'b0;
      flush_cnt_nxt = '0;
      if (cfg_ok)
        os_sel_nxt = cfg_os;
      else if (state == DRAIN || state == CLEAR)
        os_sel_nxt = pending;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = RUN;
          cnt_nxt   = 6'd0;
          if (cfg_ok) os_sel_nxt = cfg_os;
        end
        RUN: begin
          if (wrap) begin
            cnt_nxt     = 6'd0;
            dec_stb_nxt = 1'b1;
          end else if (in_vld) begin
            cnt_nxt = cnt + 6'd1;
          end
          if (cfg_ok) begin
            pending_nxt = cfg_os;
            state_nxt   = DRAIN;
            busy_nxt    = 1'b1;
          end
        end
        DRAIN: begin
          if (cfg_ok) pending_nxt = cfg_os;
          // a partially filled decimation frame completes before the flush
          if (cnt != 6'd0) begin
            if (wrap) begin
              cnt_nxt     = 6'd0;
              dec_stb_nxt = 1'b1;
            end else if (in_vld) begin
              cnt_nxt = cnt + 6'd1;
            end
          end else begin
            state_nxt     = CLEAR;
            integ_clr_nxt = 1'b1;
            flush_cnt_nxt = '0;
          end
        end
        CLEAR: begin
          cnt_nxt = 6'd0;
          if (cfg_ok) pending_nxt = cfg_os;
          if (flush_cnt == FLUSH_LAST) begin
            state_nxt     = RUN;
            integ_clr_nxt = 1'b0;
            busy_nxt      = 1'b0;
            os_sel_nxt    = pending_nxt;
          end else begin
            flush_cnt_nxt = FW'(flush_cnt + 1'b1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    ovf_cnt_nxt = ovf_cnt;
    ovf_pos_nxt = ovf_pos;
    ovf_neg_nxt = ovf_neg;
    if (ovf_clr) begin
      ovf_cnt_nxt = '0;
      ovf_pos_nxt = 1'b0;
      ovf_neg_nxt = 1'b0;
    end
    // flush-time truncations come from the clear itself, not real overflow
    if (trunc_evt && state != CLEAR) begin
      if (ovf_clr)
        ovf_cnt_nxt = CW'(1);
      else if (ovf_cnt != {CW{1'b1}})
        ovf_cnt_nxt = ovf_cnt + CW'(1);
      if (flag_t[1]) ovf_neg_nxt = 1'b1;
      else           ovf_pos_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    flag_q <= flag_t[0];
    if (reset) begin
      state     <= IDLE;
      pending   <= 3'd0;
      os_sel    <= 3'd0;
      cnt       <= 6'd0;
      flush_cnt <= '0;
      dec_stb   <= 1'b0;
      integ_clr <= 1'b0;
      busy      <= 1'b0;
      cfg_err   <= 1'b0;
      ovf_cnt   <= '0;
      ovf_pos   <= 1'b0;
      ovf_neg   <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      os_sel    <= os_sel_nxt;
      cnt       <= cnt_nxt;
      flush_cnt <= flush_cnt_nxt;
      dec_stb   <= dec_stb_nxt;
      integ_clr <= integ_clr_nxt;
      busy      <= busy_nxt;
      cfg_err   <= cfg_err_nxt;
      ovf_cnt   <= ovf_cnt_nxt;
      ovf_pos   <= ovf_pos_nxt;
      ovf_neg   <= ovf_neg_nxt;
    end
  end

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// tb/tb_cic_dec_ctrl.sv - self-checking bench for cic_dec_ctrl
module tb_cic_dec_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1, en = 1'b0, in_vld = 1'b0, cfg_load = 1'b0, ovf_clr = 1'b0;
  logic [2:0] cfg_os = 3'd0;
  logic [1:0] flag_t = 2'd0;
  logic [2:0] os_sel;
  logic       dec_stb, integ_clr, busy, cfg_err, ovf_pos, ovf_neg;
  logic [7:0] ovf_cnt;

  int vecs = 0;
  int errs = 0;

  cic_dec_ctrl #(.FLUSH_CYC(4), .CW(8)) dut (
    .clk(clk), .reset(reset), .en(en), .in_vld(in_vld), .cfg_load(cfg_load),
    .cfg_os(cfg_os), .flag_t(flag_t), .ovf_clr(ovf_clr), .os_sel(os_sel),
    .dec_stb(dec_stb), .integ_clr(integ_clr), .busy(busy), .cfg_err(cfg_err),
    .ovf_cnt(ovf_cnt), .ovf_pos(ovf_pos), .ovf_neg(ovf_neg)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; en = 1'b0; in_vld = 1'b0; cfg_load = 1'b0; cfg_os = 3'd0; ovf_clr = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic enter_run(input int os);
    cfg_load = 1'b1; cfg_os = os[2:0]; en = 1'b0;
    tick();
    cfg_load = 1'b0;
    vecs++;
    if (os_sel !== os[2:0] || integ_clr !== 1'b0) begin
      errs++;
      $display("FAIL idle_load: os_sel=%0d integ_clr=%0b expected os_sel=%0d integ_clr=0", os_sel, integ_clr, os);
    end
    en = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    flag_t = 2'b01;
    do_reset();
    vecs++;
    if ({os_sel, dec_stb, integ_clr, busy, cfg_err, ovf_cnt, ovf_pos, ovf_neg} !== 16'd0) begin
      errs++;
      $display("FAIL reset_outputs: got %h expected 0",
               {os_sel, dec_stb, integ_clr, busy, cfg_err, ovf_cnt, ovf_pos, ovf_neg});
    end
    tick();
    vecs++;
    if (ovf_cnt !== 8'd0) begin
      errs++;
      $display("FAIL reset_flag_copy: ovf_cnt=%0d expected 0", ovf_cnt);
    end
  endtask

  task automatic test_decim_basic;
    do_reset();
    enter_run(2);
    in_vld = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      vecs++;
      if (dec_stb !== (k % 4 == 0)) begin
        errs++;
        $display("FAIL decim_os2 sample %0d: dec_stb=%0b expected %0b", k, dec_stb, (k % 4 == 0));
      end
    end
    in_vld = 1'b0;
    tick();
    vecs++;
    if (dec_stb !== 1'b0) begin
      errs++;
      $display("FAIL decim_os2_tail: dec_stb=%0b expected 0", dec_stb);
    end
  endtask

  task automatic test_decim_random;
    for (int t = 0; t < 7; t++) begin
      int os, n;
      logic v, exp_stb;
      os = (t == 0) ? 6 : $urandom_range(0, 6);
      n = 0;
      do_reset();
      enter_run(os);
      for (int c = 0; c < 160; c++) begin
        v = ($urandom_range(0, 3) != 0);
        in_vld = v;
        tick();
        if (v) n++;
        exp_stb = v && (n % (1 << os) == 0);
        vecs++;
        if (dec_stb !== exp_stb) begin
          errs++;
          $display("FAIL decim_rand os=%0d sample %0d: dec_stb=%0b expected %0b", os, n, dec_stb, exp_stb);
        end
      end
      in_vld = 1'b0;
    end
  endtask

  task automatic test_reconfig;
    int clr_cycles;
    bit done;
    do_reset();
    enter_run(3);
    in_vld = 1'b1;
    repeat (5) tick();
    in_vld = 1'b0;
    cfg_load = 1'b1; cfg_os = 3'd1;
    tick();
    cfg_load = 1'b0;
    vecs++;
    if (busy !== 1'b1 || os_sel !== 3'd3 || cfg_err !== 1'b0) begin
      errs++;
      $display("FAIL reconfig_start: busy=%0b os_sel=%0d cfg_err=%0b expected 1,3,0", busy, os_sel, cfg_err);
    end
    for (int k = 1; k <= 3; k++) begin
      in_vld = 1'b1;
      tick();
      vecs++;
      if (dec_stb !== (k == 3) || busy !== 1'b1 || integ_clr !== 1'b0) begin
        errs++;
        $display("FAIL drain sample %0d: dec_stb=%0b busy=%0b integ_clr=%0b expected %0b,1,0",
                 k, dec_stb, busy, integ_clr, (k == 3));
      end
      if (k < 3) begin
        in_vld = 1'b0;
        tick();
      end
    end
    clr_cycles = 0;
    done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      vecs++;
      if (dec_stb !== 1'b0) begin
        errs++;
        $display("FAIL flush_strobe: dec_stb=%0b expected 0", dec_stb);
      end
      if (integ_clr) begin
        clr_cycles++;
        vecs++;
        if (busy !== 1'b1 || os_sel !== 3'd3) begin
          errs++;
          $display("FAIL flush_state: busy=%0b os_sel=%0d expected 1,3", busy, os_sel);
        end
        flag_t = {1'b1, ~flag_t[0]};
      end else if (clr_cycles > 0) begin
        done = 1'b1;
        break;
      end
    end
    vecs++;
    if (!done || clr_cycles != 4 || busy !== 1'b0 || os_sel !== 3'd1 || ovf_cnt !== 8'd0) begin
      errs++;
      $display("FAIL flush_end: done=%0b clr_cycles=%0d busy=%0b os_sel=%0d ovf_cnt=%0d expected 1,4,0,1,0",
               done, clr_cycles, busy, os_sel, ovf_cnt);
    end
    tick();
    vecs++;
    if (dec_stb !== 1'b0) begin
      errs++;
      $display("FAIL post_flush_1: dec_stb=%0b expected 0", dec_stb);
    end
    tick();
    vecs++;
    if (dec_stb !== 1'b1) begin
      errs++;
      $display("FAIL post_flush_2: dec_stb=%0b expected 1", dec_stb);
    end
    in_vld = 1'b0;
  endtask

  task automatic test_cfg_err;
    int n;
    do_reset();
    enter_run(1);
    n = 0;
    in_vld = 1'b1;
    cfg_os = 3'd7;
    for (int c = 0; c < 10; c++) begin
      cfg_load = (c == 3);
      tick();
      n++;
      vecs++;
      if (cfg_err !== (c == 3) || dec_stb !== (n % 2 == 0) || os_sel !== 3'd1 || busy !== 1'b0) begin
        errs++;
        $display("FAIL cfg_err cycle %0d: cfg_err=%0b dec_stb=%0b os_sel=%0d busy=%0b expected %0b,%0b,1,0",
                 c, cfg_err, dec_stb, os_sel, busy, (c == 3), (n % 2 == 0));
      end
    end
    cfg_load = 1'b0;
    in_vld = 1'b0;
  endtask

  task automatic test_ovf;
    int n, exp_cnt;
    do_reset();
    n = 0;
    for (int i = 0; i < 300; i++) begin
      flag_t = {1'b1, ~flag_t[0]};
      tick();
      n++;
      exp_cnt = (n > 255) ? 255 : n;
      vecs++;
      if (ovf_cnt !== exp_cnt[7:0] || ovf_neg !== 1'b1 || ovf_pos !== 1'b0) begin
        errs++;
        $display("FAIL ovf_count toggle %0d: ovf_cnt=%0d neg=%0b pos=%0b expected %0d,1,0",
                 n, ovf_cnt, ovf_neg, ovf_pos, exp_cnt);
      end
      if ($urandom_range(0, 1) != 0) tick();
    end
    ovf_clr = 1'b1;
    flag_t = {1'b0, ~flag_t[0]};
    tick();
    ovf_clr = 1'b0;
    vecs++;
    if (ovf_cnt !== 8'd1 || ovf_pos !== 1'b1 || ovf_neg !== 1'b0) begin
      errs++;
      $display("FAIL ovf_clr_evt: ovf_cnt=%0d pos=%0b neg=%0b expected 1,1,0", ovf_cnt, ovf_pos, ovf_neg);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    vecs++;
    if (ovf_cnt !== 8'd0 || ovf_pos !== 1'b0 || ovf_neg !== 1'b0) begin
      errs++;
      $display("FAIL ovf_clr: ovf_cnt=%0d pos=%0b neg=%0b expected 0,0,0", ovf_cnt, ovf_pos, ovf_neg);
    end
  endtask

  task automatic test_reset_mid_clear;
    bit seen;
    do_reset();
    enter_run(0);
    cfg_load = 1'b1; cfg_os = 3'd5;
    tick();
    cfg_load = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (integ_clr) begin
        seen = 1'b1;
        break;
      end
    end
    tick();
    vecs++;
    if (!seen || integ_clr !== 1'b1) begin
      errs++;
      $display("FAIL clear_entry: seen=%0b integ_clr=%0b expected 1,1", seen, integ_clr);
    end
    reset = 1'b1;
    flag_t = {1'b0, ~flag_t[0]};
    tick();
    reset = 1'b0;
    vecs++;
    if ({os_sel, dec_stb, integ_clr, busy, cfg_err, ovf_cnt, ovf_pos, ovf_neg} !== 16'd0) begin
      errs++;
      $display("FAIL reset_mid_clear: got %h expected 0",
               {os_sel, dec_stb, integ_clr, busy, cfg_err, ovf_cnt, ovf_pos, ovf_neg});
    end
    tick();
    vecs++;
    if (os_sel !== 3'd0 || integ_clr !== 1'b0 || ovf_cnt !== 8'd0) begin
      errs++;
      $display("FAIL after_reset: os_sel=%0d integ_clr=%0b ovf_cnt=%0d expected 0,0,0", os_sel, integ_clr, ovf_cnt);
    end
  endtask

  task automatic test_en_drop;
    do_reset();
    enter_run(3);
    in_vld = 1'b1;
    repeat (2) tick();
    in_vld = 1'b0;
    cfg_load = 1'b1; cfg_os = 3'd4;
    tick();
    cfg_load = 1'b0;
    vecs++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL en_drop_drain: busy=%0b expected 1", busy);
    end
    en = 1'b0;
    tick();
    vecs++;
    if (os_sel !== 3'd4 || busy !== 1'b0 || integ_clr !== 1'b0 || dec_stb !== 1'b0) begin
      errs++;
      $display("FAIL en_drop: os_sel=%0d busy=%0b integ_clr=%0b dec_stb=%0b expected 4,0,0,0",
               os_sel, busy, integ_clr, dec_stb);
    end
    repeat (3) begin
      tick();
      vecs++;
      if (integ_clr !== 1'b0) begin
        errs++;
        $display("FAIL en_drop_idle: integ_clr=%0b expected 0", integ_clr);
      end
    end
    en = 1'b1;
    tick();
    in_vld = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      vecs++;
      if (dec_stb !== (k == 16)) begin
        errs++;
        $display("FAIL en_resume sample %0d: dec_stb=%0b expected %0b", k, dec_stb, (k == 16));
      end
    end
    in_vld = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decim_basic();
    test_decim_random();
    test_reconfig();
    test_cfg_err();
    test_ovf();
    test_reset_mid_clear();
    test_en_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/cic_dec_ctrl.md
CIC_DEC_CTRL -- requirements
Module: cic_dec_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYC, default 4, which sets the number of cycles integ_clr is held during a reconfiguration.
REQ-002 SHALL have parameter CW, default 8, which sets the width of the overflow event counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit: decimator enable.
REQ-006 SHALL have port in_vld, input, 1 bit: one-cycle input-sample strobe.
REQ-007 SHALL have port cfg_load, input, 1 bit: request to change the oversampling selection.
REQ-008 SHALL have port cfg_os, input, 3 bits: requested oversampling code.
REQ-009 SHALL have port flag_t, input, 2 bits: integrator truncation flag; bit0 toggles on each truncation, bit1 is the sign of the truncated sum.
REQ-010 SHALL have port ovf_clr, input, 1 bit: clears the overflow statistics.
REQ-011 SHALL have port os_sel, output, 3 bits: applied oversampling code, driven to the integrator.
REQ-012 SHALL have port dec_stb, output, 1 bit: one-cycle decimated-output strobe (the clk_div enable).
REQ-013 SHALL have port integ_clr, output, 1 bit: integrator/comb clear.
REQ-014 SHALL have port busy, output, 1 bit: reconfiguration in progress.
REQ-015 SHALL have port cfg_err, output, 1 bit: one-cycle pulse on an invalid configuration request.
REQ-016 SHALL have port ovf_cnt, output, CW bits: saturating count of truncation events.
REQ-017 SHALL have port ovf_pos, output, 1 bit: sticky positive-overflow flag.
REQ-018 SHALL have port ovf_neg, output, 1 bit: sticky negative-overflow flag.

Function
REQ-019 SHALL implement states IDLE, RUN, DRAIN and CLEAR, with all outputs registered.
REQ-020 SHALL use decimation ratio R = 2^os_sel (os_sel 0..6, giving R = 1..64), with a 6-bit sample counter cnt.
REQ-021 SHALL, in RUN, increment cnt on each in_vld, and on the in_vld where cnt==R-1 wrap cnt to 0 and assert dec_stb for exactly the following cycle.
REQ-022 SHALL, with R=1, assert dec_stb the cycle after every in_vld.
REQ-023 SHALL treat cfg_os==3'b111 as invalid: pulse cfg_err for 1 cycle, ignore the request, and leave state unchanged.
REQ-024 SHALL, on a valid cfg_load in IDLE, load os_sel on the next cycle without asserting integ_clr.
REQ-025 SHALL, on a valid cfg_load in RUN, latch the value as pending, move to DRAIN, and assert busy.
REQ-026 SHALL, in DRAIN with cnt!=0, keep counting in_vld; the completing in_vld still produces dec_stb.
REQ-027 SHALL, in DRAIN with cnt==0, drop in_vld and move to CLEAR on the next cycle.
REQ-028 SHALL, in CLEAR, hold integ_clr high for exactly FLUSH_CYC cycles, drop in_vld and hold cnt=0.
REQ-029 SHALL, at the end of CLEAR, apply os_sel=pending in the same edge that returns the state to RUN, and deassert busy and integ_clr.
REQ-030 SHALL, on a valid cfg_load during DRAIN or CLEAR, overwrite pending without restarting the CLEAR count.
REQ-031 SHALL, when en=0 in any state, go to IDLE on the next cycle: cnt=0, dec_stb=0, integ_clr=0, busy=0, and any pending value applied to os_sel.
REQ-032 SHALL move from IDLE to RUN when en=1, with cnt=0.
REQ-033 SHALL keep a registered copy of flag_t[0] updated every cycle, and flag a truncation event when flag_t[0] differs from that copy.
REQ-034 SHALL, on a truncation event outside CLEAR, increment ovf_cnt, saturating at 2^CW-1.
REQ-035 SHALL, on a truncation event outside CLEAR, set ovf_pos if flag_t[1]==0 and set ovf_neg if flag_t[1]==1.
REQ-036 SHALL ignore truncation events that occur in CLEAR.
REQ-037 SHALL, on ovf_clr, zero ovf_cnt, ovf_pos and ovf_neg.
REQ-038 SHALL, when ovf_clr coincides with a truncation event, give ovf_cnt=1 with only the matching sticky flag set.

Reset
REQ-039 SHALL, on reset=1 at a rising edge, set state=IDLE, os_sel=0, pending=0, cnt=0, dec_stb=0, integ_clr=0, busy=0, cfg_err=0, ovf_cnt=0, ovf_pos=0, ovf_neg=0, and load the flag_t[0] copy from the current flag_t[0].
REQ-040 SHALL let reset override every other input, including mid-DRAIN and mid-CLEAR.

Verification
REQ-041 SHALL be verified with: os_sel=2, en=1, 12 consecutive in_vld -> dec_stb pulses after samples 4, 8 and 12, with none elsewhere.
REQ-042 SHALL be verified with: os_sel=3, cnt=5, cfg_load with cfg_os=1 -> the 3 further in_vld are counted, dec_stb fires once, integ_clr is high for 4 cycles with busy=1, then os_sel=1 and state is RUN.
REQ-043 SHALL be verified with: cfg_load with cfg_os=7 while in RUN -> a cfg_err pulse of 1 cycle, with os_sel, state and dec_stb cadence unchanged.
REQ-044 SHALL be verified with: 300 flag_t[0] toggles carrying flag_t[1]=1 -> ovf_cnt=255, ovf_neg=1, ovf_pos=0; then ovf_clr coinciding with a toggle carrying flag_t[1]=0 -> ovf_cnt=1, ovf_pos=1, ovf_neg=0.
REQ-045 SHALL be verified with: reset asserted in the 2nd CLEAR cycle -> all outputs take their reset values next cycle and os_sel=0.
REQ-046 SHALL be verified with: en dropped during DRAIN with pending=4 -> IDLE next cycle with os_sel=4, busy=0, and no integ_clr pulse.
